// File: rtl/switch_dest_tag_if.sv
// AXI-Stream bundle shared by the untagged ingress and tagged egress of switch_dest_tag.
// tdest is only meaningful on the tagged side.
interface switch_dest_tag_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned KEEP_W = DATA_W / 8,
  parameter int unsigned ID_W   = 8,
  parameter int unsigned USER_W = 17,
  parameter int unsigned DEST_W = 4
);
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic [USER_W-1:0] tuser;
  logic [DEST_W-1:0] tdest;

  modport master (
    output tdata, tkeep, tvalid, tlast, tid, tuser, tdest,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast, tid, tuser, tdest,
    output tready
  );
endinterface

// File: rtl/switch_dest_tag.sv
// Ingress tagger: looks up the destination MAC of each frame in a small CAM-style table
// and forwards the frame through one register stage with a per-frame tdest port mask.
module switch_dest_tag #(
  parameter int unsigned AXIS_DATA_WIDTH = 64,
  parameter int unsigned AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int unsigned AXIS_ID_WIDTH   = 8,
  parameter int unsigned AXIS_USER_WIDTH = 17,
  parameter int unsigned RADIX           = 4,
  parameter int unsigned AXIS_DEST_WIDTH = RADIX,
  parameter int unsigned PORT_INDEX      = 0,
  parameter int unsigned TABLE_SIZE      = 8,
  localparam int unsigned TBL_AW         = $clog2(TABLE_SIZE)
) (
  input  logic                       clk,
  input  logic                       rst,
  switch_dest_tag_if.slave           s_axis,
  switch_dest_tag_if.master          m_axis,
  input  logic                       cfg_wr_en,
  input  logic [TBL_AW-1:0]          cfg_wr_addr,
  input  logic [47:0]                cfg_wr_mac,
  input  logic [AXIS_DEST_WIDTH-1:0] cfg_wr_mask,
  input  logic                       cfg_wr_entry_valid,
  output logic                       status_hit,
  output logic                       status_miss,
  output logic                       status_drop
);

  typedef enum logic [1:0] {StFirst, StPass, StDrop} state_e;

  // Our own port bit; frames are never reflected back out of the ingress port.
  localparam logic [AXIS_DEST_WIDTH-1:0] SelfBit =
      ((PORT_INDEX < AXIS_DEST_WIDTH) && (PORT_INDEX < RADIX)) ?
      (AXIS_DEST_WIDTH'(1) << PORT_INDEX) : '0;
  localparam logic [AXIS_DEST_WIDTH-1:0] FloodMask = ~SelfBit;

  state_e                      r_state;
  state_e                      w_state_next;

  logic [47:0]                 r_tbl_mac   [TABLE_SIZE];
  logic [AXIS_DEST_WIDTH-1:0]  r_tbl_mask  [TABLE_SIZE];
  logic [TABLE_SIZE-1:0]       r_tbl_valid;

  logic [AXIS_DATA_WIDTH-1:0]  r_m_data;
  logic [AXIS_KEEP_WIDTH-1:0]  r_m_keep;
  logic                        r_m_valid;
  logic                        r_m_last;
  logic [AXIS_ID_WIDTH-1:0]    r_m_id;
  logic [AXIS_USER_WIDTH-1:0]  r_m_user;
  logic [AXIS_DEST_WIDTH-1:0]  r_m_dest;
  logic [AXIS_DEST_WIDTH-1:0]  r_mask;

  logic                        r_hit;
  logic                        r_miss;
  logic                        r_drop;

  logic [47:0]                 w_dest_mac;
  logic                        w_group;
  logic                        w_hit;
  logic [AXIS_DEST_WIDTH-1:0]  w_hit_mask;
  logic [AXIS_DEST_WIDTH-1:0]  w_mask;
  logic                        w_mask_zero;
  logic                        w_s_ready;
  logic                        w_accept;
  logic                        w_first_acc;
  logic                        w_fwd;
  logic [AXIS_DEST_WIDTH-1:0]  w_out_dest;

  assign w_dest_mac = s_axis.tdata[47:0];
  assign w_group    = w_dest_mac[0];

  // Scan high-to-low so the lowest-index matching entry wins.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_mask = '0;
    for (int i = TABLE_SIZE - 1; i >= 0; i--) begin
      if (r_tbl_valid[i] && (r_tbl_mac[i] == w_dest_mac)) begin
        w_hit      = 1'b1;
        w_hit_mask = r_tbl_mask[i];
      end
    end
  end

  assign w_mask      = (w_group || !w_hit) ? FloodMask : (w_hit_mask & ~SelfBit);
  assign w_mask_zero = (w_mask == '0);

  assign w_s_ready   = (r_state == StDrop) || !r_m_valid || m_axis.tready;
  assign w_accept    = s_axis.tvalid && w_s_ready;
  assign w_first_acc = w_accept && (r_state == StFirst);
  assign w_fwd       = w_accept && ((r_state == StPass) ||
                                    ((r_state == StFirst) && !w_mask_zero));
  assign w_out_dest  = (r_state == StFirst) ? w_mask : r_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StFirst;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StFirst: begin
        if (w_accept && !s_axis.tlast) begin
          w_state_next = w_mask_zero ? StDrop : StPass;
        end
      end
      StPass, StDrop: begin
        if (w_accept && s_axis.tlast) begin
          w_state_next = StFirst;
        end
      end
      default: w_state_next = StFirst;
    endcase
  end

  // Only valid bits need reset; stale MAC/mask contents are masked off by them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tbl_valid <= '0;
    end else if (cfg_wr_en) begin
      r_tbl_valid[cfg_wr_addr] <= cfg_wr_entry_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_wr_en) begin
      r_tbl_mac[cfg_wr_addr]  <= cfg_wr_mac;
      r_tbl_mask[cfg_wr_addr] <= cfg_wr_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask <= '0;
    end else if (w_first_acc && !w_mask_zero) begin
      r_mask <= w_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid <= 1'b0;
    end else if (m_axis.tready || !r_m_valid) begin
      r_m_valid <= w_fwd;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fwd) begin
      r_m_data <= s_axis.tdata;
      r_m_keep <= s_axis.tkeep;
      r_m_last <= s_axis.tlast;
      r_m_id   <= s_axis.tid;
      r_m_user <= s_axis.tuser;
      r_m_dest <= w_out_dest;
    end
  end

  // A zero mask reports as a drop in place of the hit/miss it would have been.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      r_hit  <= w_first_acc && !w_group && w_hit && !w_mask_zero;
      r_miss <= w_first_acc && (w_group || !w_hit) && !w_mask_zero;
      r_drop <= w_first_acc && w_mask_zero;
    end
  end

  assign s_axis.tready = w_s_ready;

  assign m_axis.tdata  = r_m_data;
  assign m_axis.tkeep  = r_m_keep;
  assign m_axis.tvalid = r_m_valid;
  assign m_axis.tlast  = r_m_last;
  assign m_axis.tid    = r_m_id;
  assign m_axis.tuser  = r_m_user;
  assign m_axis.tdest  = r_m_dest;

  assign status_hit  = r_hit;
  assign status_miss = r_miss;
  assign status_drop = r_drop;

endmodule

// File: tb/tb_switch_dest_tag.sv
// Bench for switch_dest_tag: a frame-level reference model checked every cycle, plus
// directed scenarios whose outcomes are pinned with hand-computed literals.
module tb_switch_dest_tag;

  localparam int unsigned DW   = 64;
  localparam int unsigned KW   = 8;
  localparam int unsigned IW   = 8;
  localparam int unsigned UW   = 17;
  localparam int unsigned NDST = 4;
  localparam int unsigned PORT = 0;
  localparam int unsigned TS   = 8;

  localparam logic [47:0] MacA  = 48'h05_00_00_00_00_02;  // 02:00:00:00:00:05
  localparam logic [47:0] MacC  = 48'h77_66_55_44_33_22;  // 22:33:44:55:66:77
  localparam logic [47:0] MacBc = 48'hFF_FF_FF_FF_FF_FF;

  typedef struct {
    logic [DW-1:0]   data;
    logic [KW-1:0]   keep;
    logic            last;
    logic [IW-1:0]   id;
    logic [UW-1:0]   user;
    logic [NDST-1:0] dest;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_wr_en = 1'b0;
  logic [2:0]      cfg_wr_addr = '0;
  logic [47:0]     cfg_wr_mac = '0;
  logic [NDST-1:0] cfg_wr_mask = '0;
  logic            cfg_wr_entry_valid = 1'b0;
  logic            status_hit, status_miss, status_drop;

  switch_dest_tag_if #(.DATA_W(DW), .KEEP_W(KW), .ID_W(IW), .USER_W(UW), .DEST_W(NDST)) s_if ();
  switch_dest_tag_if #(.DATA_W(DW), .KEEP_W(KW), .ID_W(IW), .USER_W(UW), .DEST_W(NDST)) m_if ();

  switch_dest_tag #(
    .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .AXIS_ID_WIDTH(IW), .AXIS_USER_WIDTH(UW),
    .RADIX(NDST), .AXIS_DEST_WIDTH(NDST), .PORT_INDEX(PORT), .TABLE_SIZE(TS)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .s_axis             (s_if),
    .m_axis             (m_if),
    .cfg_wr_en          (cfg_wr_en),
    .cfg_wr_addr        (cfg_wr_addr),
    .cfg_wr_mac         (cfg_wr_mac),
    .cfg_wr_mask        (cfg_wr_mask),
    .cfg_wr_entry_valid (cfg_wr_entry_valid),
    .status_hit         (status_hit),
    .status_miss        (status_miss),
    .status_drop        (status_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [47:0]     tbl_mac  [TS];
  logic [NDST-1:0] tbl_mask [TS];
  logic            tbl_v    [TS];
  beat_t           exp_q [$];
  logic            in_frame = 1'b0;
  logic            dropping = 1'b0;
  logic [NDST-1:0] cur_mask = '0;
  logic            e_hit = 1'b0, e_miss = 1'b0, e_drop = 1'b0;

  int              out_beats = 0, n_hit = 0, n_miss = 0, n_drop = 0;
  logic [NDST-1:0] last_tdest = '0;
  logic [NDST-1:0] dest_log [$];
  bit              bp_en = 1'b0;

  // Returns {hit, mask}.
  function automatic logic [NDST:0] lookup(input logic [47:0] mac);
    logic [NDST-1:0] self_bit = NDST'(1) << PORT;
    logic [NDST-1:0] flood = ~self_bit;
    if (mac[0]) return {1'b0, flood};
    for (int i = 0; i < int'(TS); i++) begin
      if (tbl_v[i] && tbl_mac[i] == mac) return {1'b1, tbl_mask[i] & ~self_bit};
    end
    return {1'b0, flood};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      in_frame = 1'b0;
      dropping = 1'b0;
      for (int i = 0; i < int'(TS); i++) tbl_v[i] = 1'b0;
      e_hit = 1'b0; e_miss = 1'b0; e_drop = 1'b0;
    end else begin
      chk("status_hit", 64'(status_hit), 64'(e_hit));
      chk("status_miss", 64'(status_miss), 64'(e_miss));
      chk("status_drop", 64'(status_drop), 64'(e_drop));
      chk("m_tvalid", 64'(m_if.tvalid), 64'(exp_q.size() != 0));
      chk("s_tready", 64'(s_if.tready),
          64'((in_frame && dropping) || exp_q.size() == 0 || m_if.tready));
      if (m_if.tvalid && exp_q.size() != 0) begin
        chk("tdata", m_if.tdata, exp_q[0].data);
        chk("tkeep", 64'(m_if.tkeep), 64'(exp_q[0].keep));
        chk("tlast", 64'(m_if.tlast), 64'(exp_q[0].last));
        chk("tid", 64'(m_if.tid), 64'(exp_q[0].id));
        chk("tuser", 64'(m_if.tuser), 64'(exp_q[0].user));
        chk("tdest", 64'(m_if.tdest), 64'(exp_q[0].dest));
        if (m_if.tready) begin
          out_beats++;
          last_tdest = m_if.tdest;
          dest_log.push_back(m_if.tdest);
          void'(exp_q.pop_front());
        end
      end
      if (status_hit) n_hit++;
      if (status_miss) n_miss++;
      if (status_drop) n_drop++;

      e_hit = 1'b0; e_miss = 1'b0; e_drop = 1'b0;
      if (s_if.tvalid && s_if.tready) begin
        beat_t b;
        b.data = s_if.tdata; b.keep = s_if.tkeep; b.last = s_if.tlast;
        b.id = s_if.tid; b.user = s_if.tuser; b.dest = '0;
        if (!in_frame) begin
          logic [NDST:0] r;
          r = lookup(s_if.tdata[47:0]);
          if (r[NDST-1:0] == '0) begin
            e_drop = 1'b1;
            dropping = 1'b1;
          end else begin
            if (r[NDST]) e_hit = 1'b1; else e_miss = 1'b1;
            dropping = 1'b0;
            cur_mask = r[NDST-1:0];
            b.dest = cur_mask;
            exp_q.push_back(b);
          end
          in_frame = !s_if.tlast;
        end else begin
          if (!dropping) begin
            b.dest = cur_mask;
            exp_q.push_back(b);
          end
          if (s_if.tlast) in_frame = 1'b0;
        end
      end
      // Table writes land after this cycle's lookup.
      if (cfg_wr_en) begin
        tbl_mac[cfg_wr_addr]  = cfg_wr_mac;
        tbl_mask[cfg_wr_addr] = cfg_wr_mask;
        tbl_v[cfg_wr_addr]    = cfg_wr_entry_valid;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    m_if.tready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_beat(input logic [DW-1:0] data, input logic last);
    int wait_cyc = 0;
    @(posedge clk); #1;
    s_if.tvalid = 1'b1;
    s_if.tdata  = data;
    s_if.tlast  = last;
    s_if.tkeep  = KW'($urandom);
    s_if.tid    = IW'($urandom);
    s_if.tuser  = UW'($urandom);
    @(negedge clk);
    while (!s_if.tready && wait_cyc < 200) begin
      wait_cyc++;
      @(negedge clk);
    end
    if (!s_if.tready) chk("s_tready_timeout", 64'(s_if.tready), 64'd1);
  endtask

  task automatic send_frame(input logic [47:0] mac, input int n);
    for (int b = 0; b < n; b++) begin
      if (b == 0) send_beat({16'(n), mac}, n == 1);
      else        send_beat({$urandom, $urandom}, b == n - 1);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    idle();
    while (exp_q.size() != 0 && c < 500) begin
      c++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [47:0] mac,
                           input logic [NDST-1:0] mask, input logic v);
    @(posedge clk); #1;
    cfg_wr_en = 1'b1; cfg_wr_addr = addr; cfg_wr_mac = mac;
    cfg_wr_mask = mask; cfg_wr_entry_valid = v;
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
  endtask

  task automatic clr_cnt();
    out_beats = 0; n_hit = 0; n_miss = 0; n_drop = 0;
    dest_log.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  int exp_rand_beats;

  initial begin
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0;
    s_if.tid = '0; s_if.tuser = '0; s_if.tdest = '0;
    m_if.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_if.tready), 64'd1);
    chk("rst_status", 64'({status_hit, status_miss, status_drop}), 64'd0);

    // Empty table: unicast floods to every port but ours.
    clr_cnt();
    send_frame(MacA, 3); drain();
    chk("t1_beats", 64'(out_beats), 64'd3);
    chk("t1_tdest", 64'(last_tdest), 64'b1110);
    chk("t1_miss", 64'(n_miss), 64'd1);

    // Single hit, then lowest matching index wins.
    cfg_write(3'd2, MacA, 4'b0100, 1'b1);
    clr_cnt();
    send_frame(MacA, 2); drain();
    chk("t2_tdest", 64'(last_tdest), 64'b0100);
    chk("t2_hit", 64'(n_hit), 64'd1);
    cfg_write(3'd1, MacA, 4'b1000, 1'b1);
    clr_cnt();
    send_frame(MacA, 2); drain();
    chk("t2_prio_tdest", 64'(last_tdest), 64'b1000);

    // Self-only mask: whole frame dropped, next frame forwarded.
    cfg_write(3'd1, MacA, 4'b0001, 1'b1);
    clr_cnt();
    send_frame(MacA, 4); drain();
    chk("t3_beats", 64'(out_beats), 64'd0);
    chk("t3_drop", 64'(n_drop), 64'd1);
    chk("t3_hit", 64'(n_hit), 64'd0);
    cfg_write(3'd1, MacA, 4'b0001, 1'b0);
    clr_cnt();
    send_frame(MacA, 2); drain();
    chk("t3_next_beats", 64'(out_beats), 64'd2);
    chk("t3_next_tdest", 64'(last_tdest), 64'b0100);

    // Broadcast, then alternating single-beat frames.
    clr_cnt();
    send_frame(MacBc, 2); drain();
    chk("t4_bc_tdest", 64'(last_tdest), 64'b1110);
    chk("t4_bc_miss", 64'(n_miss), 64'd1);
    clr_cnt();
    send_frame(MacA, 1); send_frame(MacBc, 1); send_frame(MacA, 1); send_frame(MacBc, 1);
    drain();
    chk("t4_alt_n", 64'(dest_log.size()), 64'd4);
    if (dest_log.size() == 4) begin
      chk("t4_alt0", 64'(dest_log[0]), 64'b0100);
      chk("t4_alt1", 64'(dest_log[1]), 64'b1110);
      chk("t4_alt2", 64'(dest_log[2]), 64'b0100);
      chk("t4_alt3", 64'(dest_log[3]), 64'b1110);
    end
    chk("t4_alt_hits", 64'(n_hit), 64'd2);

    // Random backpressure over 100 frames; MacC is self-only and therefore dropped.
    cfg_write(3'd5, MacC, 4'b0001, 1'b1);
    clr_cnt();
    exp_rand_beats = 0;
    bp_en = 1'b1;
    for (int f = 0; f < 100; f++) begin
      int sel = $urandom_range(0, 3);
      int len = $urandom_range(1, 4);
      logic [47:0] mac;
      case (sel)
        0: mac = MacA;
        1: mac = MacBc;
        2: mac = {$urandom, 16'($urandom)} & ~48'd1;
        default: mac = MacC;
      endcase
      if (mac != MacC) exp_rand_beats += len;
      send_frame(mac, len);
    end
    drain();
    bp_en = 1'b0;
    chk("t5_beats", 64'(out_beats), 64'(exp_rand_beats));
    chk("t5_frames", 64'(n_hit + n_miss + n_drop), 64'd100);

    // Rewrite mid-frame: in-flight frame keeps old tdest.
    clr_cnt();
    fork
      send_frame(MacA, 4);
      begin
        repeat (2) @(posedge clk);
        cfg_write(3'd2, MacA, 4'b0010, 1'b1);
      end
    join
    drain();
    chk("t6_old_n", 64'(dest_log.size()), 64'd4);
    if (dest_log.size() == 4) chk("t6_old_last", 64'(dest_log[3]), 64'b0100);
    clr_cnt();
    send_frame(MacA, 2); drain();
    chk("t6_new_tdest", 64'(last_tdest), 64'b0010);

    // Reset mid-frame: the rest is a new frame against an empty table.
    send_beat({16'h0, MacA}, 1'b0);
    send_beat(64'h1234_5678_9abc_def1, 1'b0);
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clr_cnt();
    send_beat(64'hAAAA_0000_0000_0010, 1'b0);
    send_beat(64'h5555_5555_5555_5555, 1'b1);
    drain();
    chk("t7_beats", 64'(out_beats), 64'd2);
    chk("t7_tdest", 64'(last_tdest), 64'b1110);
    chk("t7_miss", 64'(n_miss), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_dest_tag.md
SWITCH_DEST_TAG -- requirements
Module: switch_dest_tag

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 64, data bus width in bits; legal values are multiples of 8 and at least 48.
REQ-002 SHALL have parameter AXIS_KEEP_WIDTH, default AXIS_DATA_WIDTH/8, tkeep width.
REQ-003 SHALL have parameter AXIS_ID_WIDTH, default 8, tid width, passed through unchanged.
REQ-004 SHALL have parameter AXIS_USER_WIDTH, default 17, tuser width, passed through unchanged.
REQ-005 SHALL have parameter RADIX, default 4, number of switch ports.
REQ-006 SHALL have parameter AXIS_DEST_WIDTH, default RADIX, width of the one-hot/multi-hot tdest mask.
REQ-007 SHALL have parameter PORT_INDEX, default 0, this ingress port's number; that port's bit is never set in tdest.
REQ-008 SHALL have parameter TABLE_SIZE, default 8, number of MAC table entries; TBL_AW = $clog2(TABLE_SIZE).
REQ-009 SHALL have ports: clk input 1, the clock; rst input 1, the reset; one clock; reset is synchronous and active-high.
REQ-010 SHALL have ports: s_axis_tdata in AXIS_DATA_WIDTH; s_axis_tkeep in AXIS_KEEP_WIDTH; s_axis_tvalid in 1; s_axis_tready out 1; s_axis_tlast in 1; s_axis_tid in AXIS_ID_WIDTH; s_axis_tuser in AXIS_USER_WIDTH. Together these are the untagged frame input.
REQ-011 SHALL have ports: m_axis_tdata/tkeep/tvalid/tready/tlast/tid/tuser (out/out/out/in/out/out/out, same widths as REQ-010) and m_axis_tdest out AXIS_DEST_WIDTH. Together these are the tagged frame output.
REQ-012 SHALL have ports: cfg_wr_en in 1; cfg_wr_addr in TBL_AW; cfg_wr_mac in 48; cfg_wr_mask in AXIS_DEST_WIDTH; cfg_wr_entry_valid in 1. These form the table write port.
REQ-013 SHALL have ports: status_hit, status_miss and status_drop, each out 1, each a one-cycle pulse per frame.

Function
REQ-014 Destination MAC SHALL be s_axis_tdata[47:0] of the first beat of a frame, with MAC byte 0 in tdata[7:0]; cfg_wr_mac uses the same ordering.
REQ-015 The FSM SHALL have states FIRST (expecting the first beat), PASS (forwarding the remaining beats) and DROP (discarding the remaining beats).
REQ-016 In FIRST, on an accepted beat, the lookup SHALL compute a mask from the table contents in that cycle. If tdata[0]=1 (group bit), mask = all-ones with bit PORT_INDEX cleared, and the frame counts as a miss. Otherwise, on a hit the mask is the lowest-index valid matching entry's mask with bit PORT_INDEX cleared. Otherwise (miss) the mask is the flood mask.
REQ-017 A resulting mask of zero SHALL drop the frame: no output beats, status_drop pulse, and the FSM goes to DROP unless tlast is set.
REQ-018 A nonzero mask SHALL be latched for the whole frame, the beat forwarded, and the FSM goes to PASS unless tlast is set.
REQ-019 A single-beat frame (tlast on the first beat) SHALL leave the FSM in FIRST.
REQ-020 status_hit/status_miss SHALL pulse one cycle after first-beat acceptance, exactly one per frame. status_drop pulses instead of status_hit when a hit yields a zero mask.
REQ-021 PASS SHALL forward beats with the latched tdest and return to FIRST on accepted tlast.
REQ-022 DROP SHALL hold s_axis_tready=1, assert no m_axis_tvalid, and return to FIRST on accepted tlast.
REQ-023 Output SHALL be a single register stage: latency 1 cycle, tready/tvalid per AXI-Stream, data stable while tvalid && !tready.
REQ-024 In FIRST/PASS, s_axis_tready SHALL equal !m_axis_tvalid || m_axis_tready, giving full throughput with no bubbles.
REQ-025 A cfg_wr_en write SHALL take effect from the next cycle. A write in the same cycle as a first-beat acceptance does not affect that lookup.
REQ-026 Table changes SHALL NOT alter the tdest of a frame already in flight.
REQ-027 tdata, tkeep, tlast, tid and tuser SHALL pass through unmodified.

Reset
REQ-028 On rst, all table entries SHALL become invalid, the FSM SHALL enter FIRST, and m_axis_tvalid and all status outputs SHALL be 0.
REQ-029 On rst, s_axis_tready SHALL be 1 in the cycle after reset deasserts.
REQ-030 rst asserted mid-frame SHALL discard the partial frame; the next accepted beat is treated as a first beat.

Verification
REQ-031 Empty table, PORT_INDEX=0, RADIX=4, 3-beat unicast frame -> three beats with tdest=4'b1110, status_miss once.
REQ-032 Entry 2 = {MAC 02:00:00:00:00:05, mask 4'b0100, valid}, matching frame -> tdest=4'b0100, status_hit. Entries 1 and 2 both matching -> entry 1's mask used.
REQ-033 Entry with mask 4'b0001 (self only), matching 4-beat frame -> zero output beats, status_drop once, input tready=1 throughout, next frame forwarded normally.
REQ-034 Dest MAC FF:FF:FF:FF:FF:FF -> tdest=4'b1110. Alternating single-beat frames -> each gets its own lookup.
REQ-035 Random m_axis_tready backpressure over 100 frames -> output equals input beat-for-beat; no loss or duplication.
REQ-036 Table rewrite issued mid-frame -> the current frame keeps its old tdest and the next frame uses the new mask. rst mid-frame -> the remainder of the frame is treated as a new frame.
